seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// START/BUSY/DONE handshake; results held until the next DONE.
module seq_divider #(
   parameter int unsigned N_WIDTH = 16,
   parameter int unsigned D_WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [N_WIDTH-1:0] N,
   input  logic [D_WIDTH-1:0] D,
   output logic               BUSY,
   output logic               DONE,
   output logic [N_WIDTH-1:0] Q,
   output logic [D_WIDTH-1:0] R,
   output logic               DIV_BY_ZERO
);

   localparam int unsigned CntWidth = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(N_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e              state;
   logic [CntWidth-1:0] cnt;
   logic [D_WIDTH:0]    rem;
   logic [N_WIDTH-1:0]  n_shift;
   logic [N_WIDTH-1:0]  quo;
   logic [D_WIDTH-1:0]  divisor;
   logic                zero_pend;

   logic [D_WIDTH:0]    rem_shift;
   logic [D_WIDTH:0]    rem_next;
   logic [N_WIDTH-1:0]  quo_next;
   logic                fits;

   always_comb begin
      rem_shift = {rem[D_WIDTH-1:0], n_shift[N_WIDTH-1]};
      fits      = (rem_shift >= {1'b0, divisor});
      rem_next  = fits ? (rem_shift - {1'b0, divisor}) : rem_shift;
      quo_next  = N_WIDTH'({quo, fits});
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= StIdle;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         Q           <= '0;
         R           <= '0;
         DIV_BY_ZERO <= 1'b0;
         cnt         <= '0;
         rem         <= '0;
         n_shift     <= '0;
         quo         <= '0;
         divisor     <= '0;
         zero_pend   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         unique case (state)
            StIdle, StFin: begin
               if (START) begin
                  n_shift   <= N;
                  divisor   <= D;
                  rem       <= '0;
                  quo       <= '0;
                  // A zero divisor spends a single RUN cycle so DONE lands one edge later.
                  zero_pend <= (D == '0);
                  cnt       <= (D == '0) ? '0 : CntLast;
                  BUSY      <= 1'b1;
                  state     <= StRun;
               end else begin
                  state <= StIdle;
               end
            end
            StRun: begin
               if (zero_pend) begin
                  Q           <= '1;
                  R           <= '0;
                  DIV_BY_ZERO <= 1'b1;
                  DONE        <= 1'b1;
                  BUSY        <= 1'b0;
                  zero_pend   <= 1'b0;
                  state       <= StFin;
               end else begin
                  rem     <= rem_next;
                  n_shift <= n_shift << 1;
                  quo     <= quo_next;
                  if (cnt == '0) begin
                     Q           <= quo_next;
                     R           <= rem_next[D_WIDTH-1:0];
                     DIV_BY_ZERO <= 1'b0;
                     DONE        <= 1'b1;
                     BUSY        <= 1'b0;
                     state       <= StFin;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            default: begin
               BUSY  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a negedge
// monitor pops them on every DONE and checks hold behaviour in between.
module tb_seq_divider;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [15:0] N = '0;
   logic [7:0]  D = '0;
   logic        BUSY, DONE, DIV_BY_ZERO;
   logic [15:0] Q;
   logic [7:0]  R;

   seq_divider #(.N_WIDTH(16), .D_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .START(START), .N(N), .D(D),
      .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DIV_BY_ZERO(DIV_BY_ZERO)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
      int          edge_no;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   logic rst_s = 1'b1;
   logic [15:0] held_q = '0;
   logic [7:0]  held_r = '0;
   logic        held_z = 1'b0;

   always @(posedge CLK) begin
      cyc   <= cyc + 1;
      rst_s <= RST;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: result check on DONE, hold check on every other cycle.
   always @(negedge CLK) begin
      exp_t e;
      if (rst_s) begin
         held_q = '0;
         held_r = '0;
         held_z = 1'b0;
      end
      if (DONE) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("q", 32'(Q), 32'(e.q));
            chk("r", 32'(R), 32'(e.r));
            chk("div_by_zero", 32'(DIV_BY_ZERO), 32'(e.z));
            chk("done_edge", 32'(cyc), 32'(e.edge_no));
            chk("busy_at_done", 32'(BUSY), 32'd0);
         end
         held_q = Q;
         held_r = R;
         held_z = DIV_BY_ZERO;
      end else begin
         chk("hold_q", 32'(Q), 32'(held_q));
         chk("hold_r", 32'(R), 32'(held_r));
         chk("hold_z", 32'(DIV_BY_ZERO), 32'(held_z));
      end
   end

   // Called at a negedge; the next posedge accepts. lat = edge at which DONE is seen.
   task automatic issue(input logic [15:0] n, input logic [7:0] d, input bit push,
                        input logic [15:0] q, input logic [7:0] r, input logic z,
                        input int lat);
      exp_t e;
      N     = n;
      D     = d;
      START = 1'b1;
      if (push) begin
         e.q = q; e.r = r; e.z = z; e.edge_no = cyc + lat;
         sb.push_back(e);
      end
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (sb.size() != 0 && budget < 200) begin
         @(negedge CLK);
         budget++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 32'd1, 32'd0);
         sb.delete();
      end
      @(negedge CLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      int guard;
      int base;
      logic [15:0] rn;
      logic [7:0]  rd;

      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_q", 32'(Q), 32'd0);
      chk("rst_r", 32'(R), 32'd0);
      chk("rst_dbz", 32'(DIV_BY_ZERO), 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // 200 / 7 with BUSY width measurement
      issue(16'd200, 8'd7, 1'b1, 16'd28, 8'd4, 1'b0, 17);
      busy_cycles = 0;
      guard = 0;
      while (!DONE && guard < 100) begin
         if (BUSY) busy_cycles++;
         @(negedge CLK);
         guard++;
      end
      chk("busy_cycles", 32'(busy_cycles), 32'd16);
      wait_idle();

      issue(16'd65535, 8'd255, 1'b1, 16'd257, 8'd0, 1'b0, 17);
      wait_idle();
      issue(16'd65535, 8'd1, 1'b1, 16'd65535, 8'd0, 1'b0, 17);
      wait_idle();
      issue(16'd5, 8'd9, 1'b1, 16'd0, 8'd5, 1'b0, 17);
      wait_idle();

      // divide by zero, then a normal op clears the flag
      issue(16'd1234, 8'd0, 1'b1, 16'hFFFF, 8'd0, 1'b1, 2);
      wait_idle();
      issue(16'd10, 8'd3, 1'b1, 16'd3, 8'd1, 1'b0, 17);
      wait_idle();

      // START at edge 5 of a running op is ignored
      base = done_cnt;
      issue(16'd200, 8'd7, 1'b1, 16'd28, 8'd4, 1'b0, 17);
      repeat (4) @(negedge CLK);
      N = 16'd99; D = 8'd3; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_idle();
      repeat (20) @(negedge CLK);
      chk("single_done", 32'(done_cnt - base), 32'd1);

      // back-to-back START during FIN
      issue(16'd1000, 8'd10, 1'b1, 16'd100, 8'd0, 1'b0, 17);
      guard = 0;
      while (!DONE && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      issue(16'd77, 8'd5, 1'b1, 16'd15, 8'd2, 1'b0, 17);
      chk("b2b_busy", 32'(BUSY), 32'd1);
      chk("b2b_done_drop", 32'(DONE), 32'd0);
      chk("b2b_q_held", 32'(Q), 32'd100);
      wait_idle();

      // reset at edge 8 of RUN aborts
      base = done_cnt;
      issue(16'd200, 8'd7, 1'b0, 16'd0, 8'd0, 1'b0, 17);
      repeat (7) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("abort_busy", 32'(BUSY), 32'd0);
      chk("abort_done", 32'(DONE), 32'd0);
      chk("abort_q", 32'(Q), 32'd0);
      chk("abort_r", 32'(R), 32'd0);
      chk("abort_dbz", 32'(DIV_BY_ZERO), 32'd0);
      repeat (25) @(negedge CLK);
      chk("abort_no_done", 32'(done_cnt - base), 32'd0);
      issue(16'd12345, 8'd123, 1'b1, 16'd100, 8'd45, 1'b0, 17);
      wait_idle();

      // random regression
      for (int i = 0; i < 1000; i++) begin
         rn = 16'($urandom);
         rd = 8'($urandom_range(1, 255));
         issue(rn, rd, 1'b1, rn / 16'(rd), 8'(rn % 16'(rd)), 1'b0, 17);
         wait_idle();
      end

      repeat (5) @(negedge CLK);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
